// File: rtl/pifo_sorted_buffer.sv
// pifo_sorted_buffer: single-clock push-in/first-out priority buffer.
// Entries are kept sorted by ascending priority, with equal priorities in
// arrival order. A full buffer, a watermark crossing or in_drop on a push
// forces a drop decision. That decision discards either the incoming entry
// or the current tail, and the discarded entry is reported on the drop port.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_valid/in_ready/in_prio/in_data push side (in_ready never back-pressures)
//   in_drop                           requests a drop decision with this push
//   out_valid/out_ready/out_prio/out_data  head entry / pop handshake
//   drop_valid/drop_prio/drop_data    registered one-cycle drop report
//   fill_count                        number of stored entries
//   drop_total                        drops since reset (wraps mod 2^32)
module pifo_sorted_buffer #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned BITPRIO        = 16,
  parameter int unsigned BITDESC        = 32,
  parameter int unsigned DROP_WATERMARK = DEPTH - 2,
  parameter int unsigned DROP_MIN_FILL  = 0,
  localparam int unsigned BITCNT        = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITPRIO-1:0] in_prio,
  input  logic [BITDESC-1:0] in_data,
  input  logic               in_drop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITPRIO-1:0] out_prio,
  output logic [BITDESC-1:0] out_data,
  output logic               drop_valid,
  output logic [BITPRIO-1:0] drop_prio,
  output logic [BITDESC-1:0] drop_data,
  output logic [BITCNT-1:0]  fill_count,
  output logic [31:0]        drop_total
);

  // Storage and status registers
  logic [BITPRIO-1:0] r_prio [DEPTH];
  logic [BITDESC-1:0] r_data [DEPTH];
  logic [BITCNT-1:0]  r_fill;
  logic               r_in_ready;
  logic               r_drop_valid;
  logic [BITPRIO-1:0] r_drop_prio;
  logic [BITDESC-1:0] r_drop_data;
  logic [31:0]        r_drop_total;

  // Next-state wires
  logic               w_pop;
  logic               w_push;
  logic [BITCNT-1:0]  w_post;
  logic [BITPRIO-1:0] w_pp_prio [DEPTH];
  logic [BITDESC-1:0] w_pp_data [DEPTH];
  logic [BITCNT-1:0]  w_pos;
  logic [BITPRIO-1:0] w_tail_prio;
  logic [BITDESC-1:0] w_tail_data;
  logic               w_full;
  logic               w_decide;
  logic               w_discard_in;
  logic               w_insert;
  logic [BITCNT-1:0]  w_nx_fill;
  logic [BITPRIO-1:0] w_nx_prio [DEPTH];
  logic [BITDESC-1:0] w_nx_data [DEPTH];
  logic [BITPRIO-1:0] w_rep_prio;
  logic [BITDESC-1:0] w_rep_data;

  // Head and status outputs come straight from registers
  assign in_ready   = r_in_ready;
  assign out_valid  = (r_fill != '0);
  assign out_prio   = r_prio[0];
  assign out_data   = r_data[0];
  assign drop_valid = r_drop_valid;
  assign drop_prio  = r_drop_prio;
  assign drop_data  = r_drop_data;
  assign fill_count = r_fill;
  assign drop_total = r_drop_total;

  // Pop first, then push/drop decision on the post-pop contents
  always_comb begin
    w_pop  = (r_fill != '0) && out_ready;
    w_push = in_valid && r_in_ready;
    w_post = r_fill - BITCNT'(w_pop);

    for (int i = 0; i < DEPTH - 1; i++) begin
      w_pp_prio[i] = w_pop ? r_prio[i+1] : r_prio[i];
      w_pp_data[i] = w_pop ? r_data[i+1] : r_data[i];
    end
    w_pp_prio[DEPTH-1] = r_prio[DEPTH-1];
    w_pp_data[DEPTH-1] = r_data[DEPTH-1];

    // Insert slot sits behind every valid entry with prio <= in_prio
    w_pos       = '0;
    w_tail_prio = '0;
    w_tail_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (BITCNT'(i) < w_post && w_pp_prio[i] <= in_prio) begin
        w_pos = w_pos + BITCNT'(1);
      end
      if (BITCNT'(i) + BITCNT'(1) == w_post) begin
        w_tail_prio = w_pp_prio[i];
        w_tail_data = w_pp_data[i];
      end
    end

    w_full   = (w_post == BITCNT'(DEPTH));
    w_decide = w_push && (w_full ||
               ((in_drop || 32'(w_post) >= DROP_WATERMARK) && 32'(w_post) > DROP_MIN_FILL));
    // Incoming loses ties with the tail so equal priorities stay stable
    w_discard_in = w_decide && (in_prio >= w_tail_prio);
    w_insert     = w_push && !w_discard_in;
    w_nx_fill    = w_post + BITCNT'(w_push && !w_decide);

    for (int i = 0; i < DEPTH; i++) begin
      w_nx_prio[i] = w_pp_prio[i];
      w_nx_data[i] = w_pp_data[i];
    end
    // On eviction the old tail shifts past w_nx_fill and is simply forgotten
    if (w_insert) begin
      if (w_pos == '0) begin
        w_nx_prio[0] = in_prio;
        w_nx_data[0] = in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (BITCNT'(i) == w_pos) begin
          w_nx_prio[i] = in_prio;
          w_nx_data[i] = in_data;
        end else if (BITCNT'(i) > w_pos) begin
          w_nx_prio[i] = w_pp_prio[i-1];
          w_nx_data[i] = w_pp_data[i-1];
        end
      end
    end

    w_rep_prio = w_discard_in ? in_prio : w_tail_prio;
    w_rep_data = w_discard_in ? in_data : w_tail_data;
  end

  // State update; reset flushes contents without drop reports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_prio[i] <= '0;
        r_data[i] <= '0;
      end
      r_fill       <= '0;
      r_in_ready   <= 1'b0;
      r_drop_valid <= 1'b0;
      r_drop_prio  <= '0;
      r_drop_data  <= '0;
      r_drop_total <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_prio[i] <= w_nx_prio[i];
        r_data[i] <= w_nx_data[i];
      end
      r_fill       <= w_nx_fill;
      r_in_ready   <= 1'b1;
      r_drop_valid <= w_decide;
      if (w_decide) begin
        r_drop_prio  <= w_rep_prio;
        r_drop_data  <= w_rep_data;
        r_drop_total <= r_drop_total + 32'd1;
      end
    end
  end

endmodule
